// File: rtl/adder_ft_pkg.sv
// adder_ft_pkg: shared constants and types for the fault-tolerant adder datapath
package adder_ft_pkg;
  localparam int NREP = 3;
  localparam int R0 = 0;
  localparam int R1 = 1;
  localparam int R2 = 2;
  typedef enum int {COPY_SINGLE = 1, COPY_TRIPLE = 3} copy_mode_e;
endpackage

// File: rtl/tmr_word_voter.sv
// tmr_word_voter: bitwise 2-of-3 majority vote with per-replica mismatch flags
module tmr_word_voter #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  output logic [W-1:0] v,
  output logic [2:0]   mis,
  output logic         nomaj
);
  assign v = (a & b) | (a & c) | (b & c);
  assign mis = {|(c ^ v), |(b ^ v), |(a ^ v)};
  // three binary inputs always have a majority on every bit
  assign nomaj = 1'b0;
endmodule

// File: rtl/adder_acc_tmr.sv
// adder_acc_tmr: triplicated registered adder/accumulator with voting, scrubbing and error counters
module adder_acc_tmr
  import adder_ft_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int OUT_COPIES = 1,
  parameter int CNT_W = 8,
  parameter int FAULT_THRESH = 4
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic [2:0]                         in_valid_i,
  output logic                               in_ready_o,
  input  logic [2:0][WIDTH-1:0]              a_i,
  input  logic [2:0][WIDTH-1:0]              b_i,
  input  logic [2:0]                         cin_i,
  input  logic [2:0]                         acc_en_i,
  output logic [OUT_COPIES-1:0]              out_valid_o,
  input  logic                               out_ready_i,
  output logic [OUT_COPIES-1:0][WIDTH-1:0]   sum_o,
  output logic [OUT_COPIES-1:0]              cout_o,
  output logic                               err_detected_o,
  output logic                               err_corrected_o,
  output logic                               err_uncorr_o,
  output logic [2:0]                         err_replica_o,
  output logic [2:0][CNT_W-1:0]              err_cnt_o,
  output logic [2:0]                         fault_o,
  input  logic                               err_cnt_clr_i
);
  typedef logic [WIDTH-1:0] word_t;
  typedef struct packed {
    logic  valid;
    logic  cout;
    word_t sum;
  } repl_t;
  localparam copy_mode_e MODE = copy_mode_e'(OUT_COPIES);
  localparam int NC = int'(MODE);
  localparam logic [CNT_W-1:0] TH = CNT_W'(FAULT_THRESH);
  repl_t [NREP-1:0] st_q, st_d;
  repl_t [NC-1:0] vote;
  logic [NC-1:0][2:0] mis;
  logic [NC-1:0] nomaj;
  logic [NREP-1:0][WIDTH:0] add;
  logic [NREP-1:0][CNT_W-1:0] cnt_d;
  logic [NREP-1:0] hit;
  logic vvalid;
  word_t vsum;
  genvar i;
  for (i = 0; i < NC; i++) begin : g_vote
    tmr_word_voter #(.W(WIDTH + 2)) u_voter (
      .a(st_q[R0]), .b(st_q[R1]), .c(st_q[R2]),
      .v(vote[i]), .mis(mis[i]), .nomaj(nomaj[i])
    );
    assign out_valid_o[i] = vote[i].valid;
    assign cout_o[i] = vote[i].cout;
    assign sum_o[i] = vote[i].sum;
  end
  assign vvalid = vote[0].valid;
  assign vsum = vote[0].sum;
  assign in_ready_o = !vvalid | out_ready_i;
  assign err_detected_o = |err_replica_o;
  assign err_corrected_o = $countones(err_replica_o) == 1;
  assign err_uncorr_o = |nomaj;
  // all voter copies see identical replicas, so OR-ing their mismatch vectors is exact
  always_comb begin
    err_replica_o = '0;
    for (int n = 0; n < NC; n++) err_replica_o |= mis[n];
  end
  // accumulate uses the voted sum so a corrupted replica never feeds the next result
  always_comb begin
    add = '0;
    st_d = st_q;
    for (int k = 0; k < NREP; k++) begin
      add[k] = {1'b0, a_i[k]} + {1'b0, acc_en_i[k] ? vsum : b_i[k]} + (WIDTH + 1)'(cin_i[k]);
      st_d[k] = (in_valid_i[k] & in_ready_o) ? repl_t'{1'b1, add[k][WIDTH], add[k][WIDTH-1:0]}
              : err_replica_o[k] ? vote[0]
              : repl_t'{st_q[k].valid & !(vvalid & out_ready_i), st_q[k].cout, st_q[k].sum};
    end
  end
  // replica state registers: load beats scrub, scrub beats hold/drain
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) st_q <= '0;
    else st_q <= st_d;
  end
  // saturating per-replica counters and the threshold crossing they produce
  always_comb begin
    cnt_d = err_cnt_o;
    hit = '0;
    for (int k = 0; k < NREP; k++) begin
      cnt_d[k] = (err_replica_o[k] && err_cnt_o[k] != '1) ? err_cnt_o[k] + 1'b1 : err_cnt_o[k];
      hit[k] = cnt_d[k] >= TH;
    end
  end
  // error bookkeeping; clear wins over a simultaneous increment
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i || err_cnt_clr_i) begin
      err_cnt_o <= '0;
      fault_o <= '0;
    end else begin
      err_cnt_o <= cnt_d;
      fault_o <= fault_o | hit;
    end
  end
endmodule
